mbx_cyc_arb: RTL and testbench

//  Cache-cycle arbiter/sequencer for the MBOX physical-address path. Shares the PMA address mux

---
 rtl/mbx_pkg.sv | 31 +++
 rtl/mbx_prio_enc.sv | 48 ++++
 rtl/mbx_cyc_arb.sv | 164 ++++++++++++++++
 tb/tb_mbx_cyc_arb.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbx_pkg.sv
// rtl/mbx_pkg.sv - shared types and grant bit positions for the MBOX cache-cycle arbiter
package mbx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WB,
        REFILL
    } arb_state_t;

    typedef enum logic [2:0] {
        SRC_EBOX     = 3'd0,
        SRC_ERA      = 3'd1,
        SRC_EBOX_CCA = 3'd2,
        SRC_CCA      = 3'd3,
        SRC_CHAN     = 3'd4,
        SRC_REFILL   = 3'd5,
        SRC_WB       = 3'd6
    } pma_src_t;

    // Grant bit index equals the PMA source code of the same requester.
    localparam int GNT_EBOX     = 0;
    localparam int GNT_ERA      = 1;
    localparam int GNT_EBOX_CCA = 2;
    localparam int GNT_CCA      = 3;
    localparam int GNT_CHAN     = 4;
    localparam int GNT_REFILL   = 5;
    localparam int GNT_WB       = 6;
    localparam int N_REQ        = 7;

endpackage

// File: rtl/mbx_prio_enc.sv
// rtl/mbx_prio_enc.sv - masked fixed-priority encoder producing a one-hot grant and PMA source
module mbx_prio_enc
    import mbx_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    input  logic             promote_ebox,
    output logic [N_REQ-1:0] grant,
    output pma_src_t         src,
    output logic             valid
);

    logic [N_REQ-1:0] live;

    always_comb begin
        live  = req & ~mask;
        grant = '0;
        src   = SRC_EBOX;
        valid = |live;
        // Writeback and refill finish a cycle already in flight, so nothing outranks them.
        if (live[GNT_WB]) begin
            grant[GNT_WB] = 1'b1;
            src           = SRC_WB;
        end else if (live[GNT_REFILL]) begin
            grant[GNT_REFILL] = 1'b1;
            src               = SRC_REFILL;
        end else if (promote_ebox && live[GNT_EBOX]) begin
            grant[GNT_EBOX] = 1'b1;
            src             = SRC_EBOX;
        end else if (live[GNT_CHAN]) begin
            grant[GNT_CHAN] = 1'b1;
            src             = SRC_CHAN;
        end else if (live[GNT_CCA]) begin
            grant[GNT_CCA] = 1'b1;
            src            = SRC_CCA;
        end else if (live[GNT_EBOX_CCA]) begin
            grant[GNT_EBOX_CCA] = 1'b1;
            src                 = SRC_EBOX_CCA;
        end else if (live[GNT_ERA]) begin
            grant[GNT_ERA] = 1'b1;
            src            = SRC_ERA;
        end else if (live[GNT_EBOX]) begin
            grant[GNT_EBOX] = 1'b1;
            src             = SRC_EBOX;
        end
    end

endmodule

// File: rtl/mbx_cyc_arb.sv
// rtl/mbx_cyc_arb.sv - MBOX cache-cycle arbiter/sequencer with writeback, refill and timeout
// Optional EBOX anti-starvation promotion enabled by defining ARB_ANTI_STARVE_EN.
module mbx_cyc_arb
    import mbx_pkg::*;
#(
    parameter int TMO_CYC    = 64,
    parameter int STARVE_LIM = 8
) (
    input  logic       clk1_mbx_h,
    input  logic       crobar_l,
    input  logic       ebox_req_h,
    input  logic       ebox_era_req_h,
    input  logic       ebox_cca_req_h,
    input  logic       chan_req_h,
    input  logic       cca_req_h,
    input  logic       cyc_done_h,
    input  logic       wb_needed_h,
    input  logic       page_fail_h,
    input  logic       hold_era_h,
    output logic [6:0] grant_h,
    output logic [2:0] pma_sel_h,
    output logic       cyc_type_hold_h,
    output logic       ebox_cyc_l,
    output logic       writeback_cyc_h,
    output logic       page_refill_cyc_l,
    output logic       ebox_retry_h,
    output logic       cyc_tmo_h
);

    localparam logic [6:0] TMO_LAST = 7'(TMO_CYC - 1);

    arb_state_t       state, state_nxt;
    logic [N_REQ-1:0] grant_q;
    pma_src_t         sel_q;
    logic             wb_pend, ref_pend, retry_q, retry_pulse_q, tmo_q;
    logic [6:0]       tmo_cnt;
    logic [N_REQ-1:0] req, mask, enc_grant;
    pma_src_t         enc_src;
    logic             enc_valid, promote, tmo_hit;

    always_comb begin
        req               = '0;
        req[GNT_WB]       = wb_pend;
        req[GNT_REFILL]   = ref_pend;
        req[GNT_CHAN]     = chan_req_h;
        req[GNT_CCA]      = cca_req_h;
        req[GNT_EBOX_CCA] = ebox_cca_req_h;
        req[GNT_ERA]      = ebox_era_req_h;
        req[GNT_EBOX]     = ebox_req_h;
        mask              = '0;
        mask[GNT_ERA]     = hold_era_h;
    end

    mbx_prio_enc u_prio_enc (
        .req          (req),
        .mask         (mask),
        .promote_ebox (promote),
        .grant        (enc_grant),
        .src          (enc_src),
        .valid        (enc_valid)
    );

    // STARVE_LIM must fit the 4-bit starvation counter.
    if (STARVE_LIM < 1 || STARVE_LIM > 15) begin : g_bad_starve_lim
        logic starve_lim_out_of_range;
    end

`ifdef ARB_ANTI_STARVE_EN
    localparam logic [3:0] STARVE_THR = 4'(STARVE_LIM);
    logic [3:0] starve_cnt;

    always_ff @(posedge clk1_mbx_h or negedge crobar_l) begin
        if (!crobar_l) begin
            starve_cnt <= '0;
        end else if (state == IDLE && enc_valid) begin
            if (enc_grant[GNT_EBOX])
                starve_cnt <= '0;
            else if (ebox_req_h && starve_cnt < STARVE_THR)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign promote = retry_q | (starve_cnt >= STARVE_THR);
`else
    assign promote = retry_q;
`endif

    assign tmo_hit = (state != IDLE) && !cyc_done_h && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk1_mbx_h or negedge crobar_l) begin
        if (!crobar_l) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enc_valid) begin
                    if (enc_grant[GNT_WB])          state_nxt = WB;
                    else if (enc_grant[GNT_REFILL]) state_nxt = REFILL;
                    else                            state_nxt = RUN;
                end
            end
            RUN, WB, REFILL: begin
                if (cyc_done_h || tmo_hit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk1_mbx_h or negedge crobar_l) begin
        if (!crobar_l) begin
            grant_q       <= '0;
            sel_q         <= SRC_EBOX;
            wb_pend       <= 1'b0;
            ref_pend      <= 1'b0;
            retry_q       <= 1'b0;
            retry_pulse_q <= 1'b0;
            tmo_q         <= 1'b0;
            tmo_cnt       <= '0;
        end else begin
            retry_pulse_q <= 1'b0;
            if (state == IDLE) begin
                if (enc_valid) begin
                    grant_q <= enc_grant;
                    sel_q   <= enc_src;
                    tmo_cnt <= '0;
                    if (enc_grant[GNT_EBOX]) retry_q <= 1'b0;
                end
            end else if (cyc_done_h) begin
                grant_q <= '0;
                sel_q   <= SRC_EBOX;
                if (state == RUN) begin
                    if (wb_needed_h) wb_pend <= 1'b1;
                    if (page_fail_h && grant_q[GNT_EBOX]) ref_pend <= 1'b1;
                end
                if (state == WB) wb_pend <= 1'b0;
                if (state == REFILL) begin
                    ref_pend      <= 1'b0;
                    retry_q       <= 1'b1;
                    retry_pulse_q <= 1'b1;
                end
            end else if (tmo_hit) begin
                // Abort leaves pend flags alone so an interrupted WB/REFILL is retried.
                grant_q <= '0;
                sel_q   <= SRC_EBOX;
                tmo_q   <= 1'b1;
            end else begin
                tmo_cnt <= tmo_cnt + 7'd1;
            end
        end
    end

    assign grant_h           = grant_q;
    assign pma_sel_h         = sel_q;
    assign cyc_type_hold_h   = |grant_q;
    assign ebox_cyc_l        = ~(grant_q[GNT_EBOX] | grant_q[GNT_ERA] | grant_q[GNT_EBOX_CCA]);
    assign writeback_cyc_h   = (state == WB);
    assign page_refill_cyc_l = (state != REFILL);
    assign ebox_retry_h      = retry_pulse_q;
    assign cyc_tmo_h         = tmo_q;

endmodule

// File: tb/tb_mbx_cyc_arb.sv
// tb/tb_mbx_cyc_arb.sv - self-checking bench for mbx_cyc_arb (honours ARB_ANTI_STARVE_EN)
module tb_mbx_cyc_arb;

    logic       clk1_mbx_h = 1'b0;
    logic       crobar_l = 1'b0;
    logic       ebox_req_h = 1'b0, ebox_era_req_h = 1'b0, ebox_cca_req_h = 1'b0;
    logic       chan_req_h = 1'b0, cca_req_h = 1'b0;
    logic       cyc_done_h = 1'b0, wb_needed_h = 1'b0, page_fail_h = 1'b0, hold_era_h = 1'b0;
    logic [6:0] grant_h;
    logic [2:0] pma_sel_h;
    logic       cyc_type_hold_h, ebox_cyc_l, writeback_cyc_h, page_refill_cyc_l;
    logic       ebox_retry_h, cyc_tmo_h;

`ifdef ARB_ANTI_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    localparam logic [6:0] G_NONE = 7'b0000000, G_EBOX = 7'b0000001, G_ERA = 7'b0000010;
    localparam logic [6:0] G_ECCA = 7'b0000100, G_CCA = 7'b0001000, G_CHAN = 7'b0010000;
    localparam logic [6:0] G_REF  = 7'b0100000, G_WB = 7'b1000000;

    mbx_cyc_arb dut (
        .clk1_mbx_h        (clk1_mbx_h),
        .crobar_l          (crobar_l),
        .ebox_req_h        (ebox_req_h),
        .ebox_era_req_h    (ebox_era_req_h),
        .ebox_cca_req_h    (ebox_cca_req_h),
        .chan_req_h        (chan_req_h),
        .cca_req_h         (cca_req_h),
        .cyc_done_h        (cyc_done_h),
        .wb_needed_h       (wb_needed_h),
        .page_fail_h       (page_fail_h),
        .hold_era_h        (hold_era_h),
        .grant_h           (grant_h),
        .pma_sel_h         (pma_sel_h),
        .cyc_type_hold_h   (cyc_type_hold_h),
        .ebox_cyc_l        (ebox_cyc_l),
        .writeback_cyc_h   (writeback_cyc_h),
        .page_refill_cyc_l (page_refill_cyc_l),
        .ebox_retry_h      (ebox_retry_h),
        .cyc_tmo_h         (cyc_tmo_h)
    );

    always #5 clk1_mbx_h = ~clk1_mbx_h;

    typedef struct {
        logic       hold;
        logic [4:0] req;      // {chan, cca, ebox_cca, era, ebox}
        logic [6:0] grant;
        logic [2:0] sel;
        logic       ecyc_l;
    } vec_t;

    typedef struct {
        string      name;
        logic [6:0] grant;
        logic [2:0] sel;
    } exp_t;

    vec_t vecs[13];
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1_mbx_h);
        #1;
    endtask

    task automatic push(input string name, input logic [6:0] g, input logic [2:0] s);
        exp_t e;
        e.name  = name;
        e.grant = g;
        e.sel   = s;
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got no entry expected one");
        end else begin
            e = sb_q.pop_front();
            chk({e.name, "_grant"}, 32'(grant_h), 32'(e.grant));
            chk({e.name, "_sel"}, 32'(pma_sel_h), 32'(e.sel));
            chk({e.name, "_hold"}, 32'(cyc_type_hold_h), 32'(|e.grant));
        end
    endtask

    task automatic drive_req(input logic hold, input logic [4:0] r);
        hold_era_h     = hold;
        chan_req_h     = r[4];
        cca_req_h      = r[3];
        ebox_cca_req_h = r[2];
        ebox_era_req_h = r[1];
        ebox_req_h     = r[0];
    endtask

    task automatic finish_cycle(input logic wb, input logic pf);
        cyc_done_h  = 1'b1;
        wb_needed_h = wb;
        page_fail_h = pf;
        tick();
        cyc_done_h  = 1'b0;
        wb_needed_h = 1'b0;
        page_fail_h = 1'b0;
    endtask

    task automatic chk_reset_outs(input string name);
        chk({name, "_grant"}, 32'(grant_h), 0);
        chk({name, "_sel"}, 32'(pma_sel_h), 0);
        chk({name, "_hold"}, 32'(cyc_type_hold_h), 0);
        chk({name, "_ecyc_l"}, 32'(ebox_cyc_l), 1);
        chk({name, "_wbcyc"}, 32'(writeback_cyc_h), 0);
        chk({name, "_refcyc_l"}, 32'(page_refill_cyc_l), 1);
        chk({name, "_retry"}, 32'(ebox_retry_h), 0);
        chk({name, "_tmo"}, 32'(cyc_tmo_h), 0);
    endtask

    task automatic do_reset();
        crobar_l = 1'b0;
        drive_req(1'b0, 5'b0);
        cyc_done_h  = 1'b0;
        wb_needed_h = 1'b0;
        page_fail_h = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk1_mbx_h);
        @(negedge clk1_mbx_h);
        crobar_l = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b0, 5'b00001, G_EBOX, 3'd0, 1'b0};
        vecs[1]  = '{1'b0, 5'b00010, G_ERA,  3'd1, 1'b0};
        vecs[2]  = '{1'b0, 5'b00100, G_ECCA, 3'd2, 1'b0};
        vecs[3]  = '{1'b0, 5'b01000, G_CCA,  3'd3, 1'b1};
        vecs[4]  = '{1'b0, 5'b10000, G_CHAN, 3'd4, 1'b1};
        vecs[5]  = '{1'b0, 5'b10001, G_CHAN, 3'd4, 1'b1};
        vecs[6]  = '{1'b0, 5'b11111, G_CHAN, 3'd4, 1'b1};
        vecs[7]  = '{1'b0, 5'b01111, G_CCA,  3'd3, 1'b1};
        vecs[8]  = '{1'b0, 5'b00111, G_ECCA, 3'd2, 1'b0};
        vecs[9]  = '{1'b0, 5'b00011, G_ERA,  3'd1, 1'b0};
        vecs[10] = '{1'b1, 5'b00010, G_NONE, 3'd0, 1'b1};
        vecs[11] = '{1'b1, 5'b00011, G_EBOX, 3'd0, 1'b0};
        vecs[12] = '{1'b1, 5'b00110, G_ECCA, 3'd2, 1'b0};

        crobar_l = 1'b0;
        #3;
        chk_reset_outs("reset");
        do_reset();

        // Single-arbitration priority table
        for (int i = 0; i < 13; i++) begin
            drive_req(vecs[i].hold, vecs[i].req);
            push($sformatf("vec%0d", i), vecs[i].grant, vecs[i].sel);
            tick();
            pop_check();
            chk($sformatf("vec%0d_ecyc_l", i), 32'(ebox_cyc_l), 32'(vecs[i].ecyc_l));
            drive_req(1'b0, 5'b0);
            if (vecs[i].grant != G_NONE) begin
                finish_cycle(1'b0, 1'b0);
                chk($sformatf("vec%0d_end", i), 32'(grant_h), 0);
            end
        end

        // ERA frozen by hold, granted the clock after release
        drive_req(1'b1, 5'b00010);
        repeat (3) begin
            push("era_held", G_NONE, 3'd0);
            tick();
            pop_check();
        end
        hold_era_h = 1'b0;
        push("era_release", G_ERA, 3'd1);
        tick();
        pop_check();
        drive_req(1'b0, 5'b0);
        finish_cycle(1'b0, 1'b0);

        // Writeback then refill then EBOX retry ahead of waiting CCA
        do_reset();
        drive_req(1'b0, 5'b00001);
        push("wbref_ebox", G_EBOX, 3'd0);
        tick();
        pop_check();
        drive_req(1'b0, 5'b01000);
        finish_cycle(1'b1, 1'b1);
        chk("wbref_gap_grant", 32'(grant_h), 0);
        push("wbref_wb", G_WB, 3'd6);
        tick();
        pop_check();
        chk("wbref_wbcyc", 32'(writeback_cyc_h), 1);
        chk("wbref_wb_ecyc_l", 32'(ebox_cyc_l), 1);
        finish_cycle(1'b0, 1'b0);
        chk("wbref_wbcyc_end", 32'(writeback_cyc_h), 0);
        push("wbref_refill", G_REF, 3'd5);
        tick();
        pop_check();
        chk("wbref_refcyc_l", 32'(page_refill_cyc_l), 0);
        drive_req(1'b0, 5'b01001);
        finish_cycle(1'b0, 1'b0);
        chk("wbref_retry_pulse", 32'(ebox_retry_h), 1);
        chk("wbref_refcyc_l_end", 32'(page_refill_cyc_l), 1);
        push("wbref_reissue", G_EBOX, 3'd0);
        tick();
        pop_check();
        chk("wbref_retry_clear", 32'(ebox_retry_h), 0);
        finish_cycle(1'b0, 1'b0);
        push("wbref_latch_spent", G_CCA, 3'd3);
        tick();
        pop_check();
        drive_req(1'b0, 5'b0);
        finish_cycle(1'b0, 1'b0);

        // Timeout: 64 clocks without cyc_done_h
        do_reset();
        drive_req(1'b0, 5'b00001);
        push("tmo_grant", G_EBOX, 3'd0);
        tick();
        pop_check();
        drive_req(1'b0, 5'b0);
        repeat (63) tick();
        chk("tmo_still_granted", 32'(grant_h), 32'(G_EBOX));
        chk("tmo_not_yet", 32'(cyc_tmo_h), 0);
        tick();
        chk("tmo_abort_grant", 32'(grant_h), 0);
        chk("tmo_flag", 32'(cyc_tmo_h), 1);
        drive_req(1'b0, 5'b01000);
        push("tmo_next", G_CCA, 3'd3);
        tick();
        pop_check();
        drive_req(1'b0, 5'b0);
        finish_cycle(1'b0, 1'b0);
        chk("tmo_sticky", 32'(cyc_tmo_h), 1);

        // Reset asserted during a writeback cycle
        do_reset();
        drive_req(1'b0, 5'b00001);
        push("rstwb_ebox", G_EBOX, 3'd0);
        tick();
        pop_check();
        drive_req(1'b0, 5'b0);
        finish_cycle(1'b1, 1'b0);
        push("rstwb_wb", G_WB, 3'd6);
        tick();
        pop_check();
        #2;
        crobar_l = 1'b0;
        #1;
        chk_reset_outs("rstwb_async");
        @(negedge clk1_mbx_h);
        crobar_l = 1'b1;
        repeat (2) begin
            push("rstwb_pend_gone", G_NONE, 3'd0);
            tick();
            pop_check();
        end
        drive_req(1'b0, 5'b00001);
        push("rstwb_after", G_EBOX, 3'd0);
        tick();
        pop_check();
        drive_req(1'b0, 5'b0);
        finish_cycle(1'b0, 1'b0);

        // chan and EBOX held: anti-starvation promotes EBOX on the 9th arbitration
        do_reset();
        drive_req(1'b0, 5'b10001);
        for (int k = 1; k <= 9; k++) begin
            if (STARVE_EN && k == 9) push($sformatf("starve_arb%0d", k), G_EBOX, 3'd0);
            else                     push($sformatf("starve_arb%0d", k), G_CHAN, 3'd4);
            tick();
            pop_check();
            finish_cycle(1'b0, 1'b0);
        end
        drive_req(1'b0, 5'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
